trap_ctrl: RTL
==============

# trap_ctrl

Trap sequencer that drives the trap-entry side of the machine-mode CSR file and redirects fetch. It accepts one exception/return event per handshake from the execute stage and samples the machine timer interrupt at instruction boundaries. It emits the one-cycle `intr`/`intr_NO`/`intr_epc` strobe the CSR file consumes, or an `mret` restore strobe. It then holds a PC redirect to `mtvec` or `mepc` until fetch accepts it.

## Interface
- DATA_WIDTH, 32, width of PC/CSR values
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- evt_valid  in  1  execute stage presents a trapping/returning instruction
- evt_ready  out  1  sequencer can accept an event
- evt_ecall / evt_ebreak / evt_illegal / evt_mret  in  1 each  event kind flags, qualified by evt_valid
- evt_pc  in  DATA_WIDTH  PC of the event instruction
- next_pc  in  DATA_WIDTH  PC of the next instruction to retire (interrupt epc)
- timer_irq  in  1  level machine-timer pending
- mstatus_mie  in  1  mstatus.MIE from CSR file
- mtvec  in  DATA_WIDTH  from CSR file
- mepc  in  DATA_WIDTH  from CSR file
- intr  out  1  trap-entry strobe to CSR file
- intr_NO  out  DATA_WIDTH  mcause value
- intr_epc  out  DATA_WIDTH  mepc value
- mret  out  1  mstatus restore strobe (MIE<=MPIE, MPIE<=1)
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  DATA_WIDTH  redirect target
- redir_ready  in  1  fetch accepts redirect
- busy  out  1  state != IDLE

## Operation
- States: IDLE, TRAP, RET, REDIR.
- IDLE: evt_ready=1. Handshake on evt_valid&&evt_ready. On accept:
  - if evt_mret alone -> RET;
  - else cause is latched by priority illegal(2) > ebreak(3) > ecall(11), epc=evt_pc, -> TRAP.
- evt_valid with no flags set is accepted and dropped (stay IDLE).
- With no accepted event, timer_irq&&mstatus_mie in IDLE latches cause {1'b1, (DATA_WIDTH-1)'d7} (0x80000007 at 32), epc=next_pc, -> TRAP.
- Same-cycle event and interrupt: the event wins. The interrupt stays level-pending and is taken on a later IDLE cycle if still enabled.
- mret combined with any other flag: exception flags win; mret ignored.
- TRAP: intr=1 exactly one cycle with the latched intr_NO/intr_epc.
  - Target {mtvec[DATA_WIDTH-1:2],2'b00} is captured (direct mode only; mode bits ignored).
  - -> REDIR.
- RET: mret=1 exactly one cycle; mepc captured as target; -> REDIR.
- REDIR: redir_valid=1, redir_pc stable until redir_valid&&redir_ready, then -> IDLE. A ready asserted earlier than REDIR has no effect.
- No new event or interrupt is accepted outside IDLE.

## Timing
- Reset (async, immediate): state IDLE. evt_ready=1; intr=0; mret=0; redir_valid=0; busy=0; intr_NO=0; intr_epc=0; redir_pc=0.
- Reset mid-sequence aborts with no strobe. A strobe cut by reset is not re-issued.
- Accept at edge N -> intr (or mret) high for cycle N+1 -> redir_valid from cycle N+2.
- Minimum trap-to-next-accept: 3 cycles when redir_ready is held high.
- intr_NO/intr_epc hold their last value after the strobe; they are only meaningful while intr=1.
- All outputs are registered or decoded from state only; no combinational path from evt_* to outputs except evt_ready=(state==IDLE).
- CSR file samples intr on the edge ending cycle N+1. A simultaneous CSR software write to the same CSR takes precedence in the CSR file; trap_ctrl does not arbitrate.

## Structure
- Shared package trap_pkg:
  - state enum (IDLE/TRAP/RET/REDIR);
  - cause constants CAUSE_ILLEGAL=2, CAUSE_BREAKPOINT=3, CAUSE_ECALL_M=11, CAUSE_MTIMER=7, interrupt bit at DATA_WIDTH-1;
  - CSR addresses 0x300/0x305/0x341/0x342.
- Sub-module trap_cause_enc: combinational priority encoder from the flags and interrupt to {take, is_ret, cause}, reused by a future vectored-mode extension.

## Test plan
- Reset asserted mid-REDIR -> redir_valid drops asynchronously, state IDLE, evt_ready=1, no intr pulse.
- evt_valid+evt_ecall, evt_pc=0x80000010, mtvec=0x80001003:
  - cycle N+1: intr=1, intr_NO=11, intr_epc=0x80000010;
  - cycle N+2: redir_pc=0x80001000 with redir_ready=1;
  - evt_ready returns at N+3.
- evt_mret, mepc=0x80000014, redir_ready held low 4 cycles -> mret one cycle; redir_valid high and redir_pc stable for 4 cycles; completes on the ready cycle.
- evt_illegal+evt_ebreak+evt_mret together -> intr_NO=2, no mret strobe.
- timer_irq=1, mstatus_mie=1 with evt_valid+evt_ebreak same cycle:
  - first intr_NO=3;
  - after redirect, second trap with intr_NO=0x80000007, intr_epc=next_pc.
- timer_irq=1, mstatus_mie=0 for 10 cycles -> no intr, busy=0 throughout.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// mcause codes and the CSR addresses the sequencer cooperates with.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    RET   = 2'd2,
    REDIR = 2'd3
  } state_e;

  // mcause exception codes; the interrupt flag is the MSB of the cause word
  localparam int unsigned CAUSE_ILLEGAL    = 2;
  localparam int unsigned CAUSE_BREAKPOINT = 3;
  localparam int unsigned CAUSE_ECALL_M    = 11;
  localparam int unsigned CAUSE_MTIMER     = 7;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of execute-stage event, CSR-file and fetch-redirect signals
// around the trap sequencer; slave is the sequencer's view.
interface trap_ctrl_if #(parameter int DATA_WIDTH = 32);

  logic                  evt_valid;
  logic                  evt_ready;
  logic                  evt_ecall;
  logic                  evt_ebreak;
  logic                  evt_illegal;
  logic                  evt_mret;
  logic [DATA_WIDTH-1:0] evt_pc;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  timer_irq;
  logic                  mstatus_mie;
  logic [DATA_WIDTH-1:0] mtvec;
  logic [DATA_WIDTH-1:0] mepc;
  logic                  intr;
  logic [DATA_WIDTH-1:0] intr_NO;
  logic [DATA_WIDTH-1:0] intr_epc;
  logic                  mret;
  logic                  redir_valid;
  logic [DATA_WIDTH-1:0] redir_pc;
  logic                  redir_ready;
  logic                  busy;

  modport slave (
    input  evt_valid, evt_ecall, evt_ebreak, evt_illegal, evt_mret, evt_pc,
           next_pc, timer_irq, mstatus_mie, mtvec, mepc, redir_ready,
    output evt_ready, intr, intr_NO, intr_epc, mret, redir_valid, redir_pc, busy
  );

  modport master (
    output evt_valid, evt_ecall, evt_ebreak, evt_illegal, evt_mret, evt_pc,
           next_pc, timer_irq, mstatus_mie, mtvec, mepc, redir_ready,
    input  evt_ready, intr, intr_NO, intr_epc, mret, redir_valid, redir_pc, busy
  );

endinterface

// File: rtl/trap_cause_enc.sv
// Priority encoder from event flags and the enabled interrupt to a trap
// decision: exceptions beat mret, any presented event beats the interrupt.
module trap_cause_enc
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  valid,
  input  logic                  ecall,
  input  logic                  ebreak,
  input  logic                  illegal,
  input  logic                  mret,
  input  logic                  irq,
  output logic                  take,
  output logic                  is_ret,
  output logic [DATA_WIDTH-1:0] cause
);

  // NOTE: every output gets a default before the if-chain so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    take   = 1'b0;
    is_ret = 1'b0;
    cause  = '0;
    if (valid) begin
      if (illegal) begin
        take  = 1'b1;
        cause = DATA_WIDTH'(CAUSE_ILLEGAL);
      end else if (ebreak) begin
        take  = 1'b1;
        cause = DATA_WIDTH'(CAUSE_BREAKPOINT);
      end else if (ecall) begin
        take  = 1'b1;
        cause = DATA_WIDTH'(CAUSE_ECALL_M);
      end else if (mret) begin
        is_ret = 1'b1;
      end
      // a flagless event is consumed without effect and also masks the irq
    end else if (irq) begin
      take  = 1'b1;
      cause = {1'b1, (DATA_WIDTH-1)'(CAUSE_MTIMER)};
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts one event or timer interrupt in IDLE, strobes the
// CSR file for one cycle, then holds a fetch redirect until it is accepted.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  state_e                state;
  state_e                state_nx;
  logic                  take;
  logic                  is_ret;
  logic [DATA_WIDTH-1:0] cause;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] epc_q;
  logic [DATA_WIDTH-1:0] target_q;

  trap_cause_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .valid   (bus.evt_valid),
    .ecall   (bus.evt_ecall),
    .ebreak  (bus.evt_ebreak),
    .illegal (bus.evt_illegal),
    .mret    (bus.evt_mret),
    .irq     (bus.timer_irq && bus.mstatus_mie),
    .take    (take),
    .is_ret  (is_ret),
    .cause   (cause)
  );

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (take)        state_nx = TRAP;
        else if (is_ret) state_nx = RET;
      end
      TRAP:  state_nx = REDIR;
      RET:   state_nx = REDIR;
      REDIR: if (bus.redir_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: these few registers are reset because their reset value is
  // visible on the outputs; wide storage arrays would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q  <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      if (state == IDLE && take) begin
        cause_q <= cause;
        // take without a presented event can only be the timer interrupt
        epc_q   <= bus.evt_valid ? bus.evt_pc : bus.next_pc;
      end
      if (state == TRAP) target_q <= {bus.mtvec[DATA_WIDTH-1:2], 2'b00};
      if (state == RET)  target_q <= bus.mepc;
    end
  end

  assign bus.evt_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.intr        = (state == TRAP);
  assign bus.mret        = (state == RET);
  assign bus.redir_valid = (state == REDIR);
  assign bus.intr_NO     = cause_q;
  assign bus.intr_epc    = epc_q;
  assign bus.redir_pc    = target_q;

endmodule
